moore_run_detector: RTL and testbench

- Moore finite-state machine that monitors a 1-bit serial input `w`.
- Asserts output `F` when the last RUN_LEN samples of `w` were all identical: a run of all 0s or a run of all 1s.
- `F` depends on the current state only (Moore), never combinationally on `w`.
- Serves as the sequence-detector leaf in the state-machine exercise set; its stimulus comes from ROM-style pattern sources driving `w` and `RST`.

---
 rtl/moore_run_pkg.sv | 39 +++
 rtl/run_counter.sv | 23 ++
 rtl/moore_run_detector.sv | 75 +++++++
 tb/tb_moore_run_detector.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/moore_run_pkg.sv
// Shared types and transition rule for the run-length Moore detector.
// Latency: none (types/functions only); backpressure: not applicable.
package moore_run_pkg;

    localparam int DEF_RUN_LEN = 4;
    localparam int DEF_CNT_W   = 4;
    // Four bits cover every legal RUN_LEN (2..15).
    localparam int ST_CNT_W    = 4;

    typedef struct packed {
        logic                init;
        logic                last;
        logic [ST_CNT_W-1:0] cnt;
    } run_state_t;

    localparam run_state_t S_RESET = '{init: 1'b0, last: 1'b0, cnt: '0};

    function automatic logic state_ok(run_state_t s, logic [ST_CNT_W-1:0] run_len);
        if (!s.init)
            return s.cnt == '0;
        return (s.cnt != '0) && (s.cnt <= run_len);
    endfunction

    function automatic run_state_t next_state(run_state_t s, logic w,
                                              logic [ST_CNT_W-1:0] run_len);
        run_state_t n;
        n      = s;
        n.init = 1'b1;
        n.last = w;
        if (!state_ok(s, run_len))
            n = S_RESET;
        else if (!s.init || (s.last != w))
            n.cnt = ST_CNT_W'(1);
        else if (s.cnt < run_len)
            n.cnt = s.cnt + 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/run_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Latency: 1 cycle; backpressure: none.
module run_counter #(
    parameter int               CNT_W = 4,
    parameter logic [CNT_W-1:0] MAX   = '1
) (
    input  logic             core_clk,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge core_clk) begin
        if (clr)
            cnt <= '0;
        else if (load1)
            cnt <= CNT_W'(1);
        else if (inc && (cnt != MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/moore_run_detector.sv
// Flags F when the last RUN_LEN samples of w were equal; MOORE_RUN_DETECTOR_STATE_OUT_EN adds state_dbg.
// Latency: F registered at the edge capturing the RUN_LEN-th equal sample; backpressure: none.
module moore_run_detector
    import moore_run_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             w,
`ifdef MOORE_RUN_DETECTOR_STATE_OUT_EN
    output logic [CNT_W:0]   state_dbg,
`endif
    output logic             F
);

    localparam logic [ST_CNT_W-1:0] RL_ST  = ST_CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0]    RL_CNT = CNT_W'(RUN_LEN);

    logic             init_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt;
    run_state_t       cur;
    run_state_t       nxt;
    logic             cnt_clr;
    logic             cnt_load1;
    logic             cnt_inc;

    always_comb begin
        cur      = S_RESET;
        cur.init = init_q;
        cur.last = last_q;
        cur.cnt  = ST_CNT_W'(cnt);
        nxt      = next_state(cur, w, RL_ST);
    end

    // The counter mirrors nxt.cnt: clear to 0, restart at 1, or step/saturate.
    always_comb begin
        cnt_clr   = RST || (nxt.cnt == '0);
        cnt_load1 = !cnt_clr && (nxt.cnt == ST_CNT_W'(1));
        cnt_inc   = !cnt_clr && !cnt_load1;
    end

    run_counter #(
        .CNT_W (CNT_W),
        .MAX   (RL_CNT)
    ) u_run_counter (
        .core_clk (CLK),
        .clr      (cnt_clr),
        .load1    (cnt_load1),
        .inc      (cnt_inc),
        .cnt      (cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            init_q <= 1'b0;
            last_q <= 1'b0;
            F      <= 1'b0;
        end else begin
            init_q <= nxt.init;
            last_q <= nxt.last;
            F      <= nxt.init && (nxt.cnt == RL_ST);
        end
    end

`ifdef MOORE_RUN_DETECTOR_STATE_OUT_EN
    assign state_dbg = {last_q, cnt};

    run_len_legal: assert property (@(posedge CLK)
        (RUN_LEN >= 2) && ((64'd1 << CNT_W) > 64'(RUN_LEN)));
`endif

endmodule

// File: tb/tb_moore_run_detector.sv
// Directed vector table, hand-written corner sequences and a random run against a history model.
module tb_moore_run_detector;

    localparam int RL = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic w   = 1'b0;
    logic F;

    int tests = 0;
    int fails = 0;

    moore_run_detector #(
        .RUN_LEN (RL),
        .CNT_W   (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .w   (w),
        .F   (F)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic rst;
        logic w;
        logic f;
    } vec_t;

    vec_t vecs[$];
    logic hist[$];

    function automatic void add(logic r, logic d, logic f);
        vec_t v;
        v.rst = r;
        v.w   = d;
        v.f   = f;
        vecs.push_back(v);
    endfunction

    // Reference: F is 1 when at least RL samples arrived since reset and the last RL agree.
    function automatic logic ref_step(logic r, logic d);
        int n;
        if (r) begin
            hist.delete();
            return 1'b0;
        end
        hist.push_back(d);
        if (hist.size() > 64)
            void'(hist.pop_front());
        n = hist.size();
        if (n < RL)
            return 1'b0;
        for (int i = n - RL; i < n; i++)
            if (hist[i] != d)
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string name, int idx, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: F=%b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step(logic r, logic d);
        @(negedge CLK);
        RST = r;
        w   = d;
        @(posedge CLK);
        #1;
    endtask

    logic seq6 [20];
    logic rr;
    logic dd;
    logic ee;

    initial begin
        // 1: reset with w toggling
        add(1, 0, 0); add(1, 1, 0);
        // 2: four ones, then saturation
        for (int i = 1; i <= 7; i++) add(0, 1, (i >= 4));
        // 3: four zeros then a one
        add(1, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 0, (i == 4));
        add(0, 1, 0);
        // 4: alternating
        add(1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, logic'(i % 2), 0);
        // 5: run discarded by reset
        add(1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0);
        add(1, 1, 0);
        for (int i = 1; i <= 4; i++) add(0, 1, (i == 4));
        // 6: mixed ROM-style sequence, F after samples 4, 12, 13, 20
        seq6 = '{0,0,0,0,1,1,1,0,1,1,1,1,1,0,0,1,0,0,0,0};
        add(1, 0, 0);
        for (int i = 0; i < 20; i++)
            add(0, seq6[i], (i == 3) || (i == 11) || (i == 12) || (i == 19));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].w);
            chk("vec", i, F, vecs[i].f);
        end

        // Long run of ones broken directly into zeros: F needs four fresh zeros.
        step(1, 1);
        chk("brk_rst", 0, F, 1'b0);
        for (int i = 1; i <= 10; i++) step(0, 1);
        chk("brk_sat", 0, F, 1'b1);
        step(0, 0);
        chk("brk_drop", 0, F, 1'b0);
        for (int i = 2; i <= 3; i++) begin
            step(0, 0);
            chk("brk_z", i, F, 1'b0);
        end
        step(0, 0);
        chk("brk_z", 4, F, 1'b1);
        // Reset mid-detection takes priority over a matching w.
        step(1, 0);
        chk("brk_prio", 0, F, 1'b0);
        step(0, 0);
        chk("brk_post", 0, F, 1'b0);

        // Random stimulus biased toward runs, with occasional resets.
        rr = 1'b1;
        dd = 1'b0;
        ee = ref_step(rr, dd);
        step(rr, dd);
        chk("rand", -1, F, ee);
        for (int i = 0; i < 2000; i++) begin
            rr = ($urandom_range(49) == 0);
            if ($urandom_range(3) == 0)
                dd = ~dd;
            ee = ref_step(rr, dd);
            step(rr, dd);
            chk("rand", i, F, ee);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
